audio_voice_sequencer: RTL

- Parametrised multi-channel sample player for the game audio path.
- Each channel walks an external async-read sample ROM (distributed ROM, combinational read) at a fixed sample rate, with one-shot or looped playback.
- Channels are merged into one sample stream by fixed priority; an optional mode mixes them additively instead.
- The output feeds the existing audio_PWM stage. A power-up/reset cue channel is built in.

---
 rtl/audio_voice_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/audio_voice_sequencer.sv
// Multi-channel ROM sample player: per-channel one-shot/looped playback at a fixed tick rate.
// Channels merge by highest-index priority; define AUDIO_MIX_EN for a saturating additive mix.
//
// state  | meaning
// S_IDLE | channel silent, address held at 0, waiting for a pending start
// S_PLAY | channel steps one ROM address per tick, wraps or stops at ch_len-1
module audio_voice_sequencer #(
  parameter int NUM_CH     = 5,
  parameter int SAMPLE_W   = 8,
  parameter int ADDR_W     = 15,
  parameter int CLK_DIV    = 8125,
  parameter int BOOT_CH    = NUM_CH - 1,
  parameter int BOOT_DELAY = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            trig,
  input  logic [NUM_CH-1:0]            loop,
  input  logic [NUM_CH*ADDR_W-1:0]     ch_len,
  output logic [NUM_CH*ADDR_W-1:0]     rom_addr,
  input  logic [NUM_CH*SAMPLE_W-1:0]   rom_data,
  output logic [SAMPLE_W-1:0]          sample_out,
  output logic                         sample_valid,
  output logic [NUM_CH-1:0]            busy
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (BOOT_DELAY > 0) ? $clog2(BOOT_DELAY + 1) : 1;
  localparam logic [SAMPLE_W-1:0] MID = {1'b1, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic {S_IDLE, S_PLAY} ch_state_t;

  ch_state_t           state [NUM_CH];
  logic [ADDR_W-1:0]   addr  [NUM_CH];
  logic [ADDR_W-1:0]   len   [NUM_CH];
  logic [SAMPLE_W-1:0] data  [NUM_CH];

  logic [CW-1:0]       div_cnt;
  logic [BW-1:0]       boot_cnt;
  logic [NUM_CH-1:0]   trig_q;
  logic [NUM_CH-1:0]   pending;
  logic [NUM_CH-1:0]   trig_edge;
  logic [NUM_CH-1:0]   req;
  logic [NUM_CH-1:0]   at_end;
  logic                tick;
  logic                boot_fire;
  logic [SAMPLE_W-1:0] merged;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign len[g]  = ch_len[g*ADDR_W +: ADDR_W];
    assign data[g] = rom_data[g*SAMPLE_W +: SAMPLE_W];
    assign rom_addr[g*ADDR_W +: ADDR_W] = addr[g];
    // A zero length seen mid-play is treated as an immediate end so the address stays bounded.
    assign at_end[g] = (len[g] == '0) || (addr[g] >= len[g] - 1'b1);
  end

  assign tick      = (div_cnt == CW'(CLK_DIV - 1));
  assign trig_edge = trig & ~trig_q;
  assign boot_fire = (BOOT_DELAY != 0) && tick && (boot_cnt == BW'(1));

  // The boot cue is consumed on the very tick the delay expires.
  always_comb begin
    req = pending;
    if (boot_fire) req[BOOT_CH] = 1'b1;
  end

`ifdef AUDIO_MIX_EN
  localparam int SUM_W = SAMPLE_W + ((NUM_CH > 1) ? $clog2(NUM_CH) : 0);
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'((1 << (SAMPLE_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(-(1 << (SAMPLE_W - 1)));

  logic signed [SUM_W-1:0]    mix_sum;
  logic signed [SAMPLE_W-1:0] contrib;
  logic        [SUM_W-1:0]    mix_sat;

  // Offset-binary minus midscale is the same bits with the MSB inverted.
  always_comb begin
    mix_sum = '0;
    contrib = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state[i] == S_PLAY) begin
        contrib = $signed({~data[i][SAMPLE_W-1], data[i][SAMPLE_W-2:0]});
        mix_sum = mix_sum + SUM_W'(contrib);
      end
    end
    if (mix_sum > SAT_HI)      mix_sat = SAT_HI;
    else if (mix_sum < SAT_LO) mix_sat = SAT_LO;
    else                       mix_sat = mix_sum;
    merged = {~mix_sat[SAMPLE_W-1], mix_sat[SAMPLE_W-2:0]};
  end
`else
  always_comb begin
    merged = MID;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state[i] == S_PLAY) merged = data[i];
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt      <= '0;
      boot_cnt     <= BW'(BOOT_DELAY);
      trig_q       <= '0;
      pending      <= '0;
      sample_out   <= MID;
      sample_valid <= 1'b0;
      busy         <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= S_IDLE;
        addr[i]  <= '0;
      end
    end else begin
      trig_q       <= trig;
      sample_valid <= tick;
      if (tick) begin
        div_cnt    <= '0;
        pending    <= trig_edge;
        sample_out <= merged;
        if (boot_cnt != '0) boot_cnt <= boot_cnt - 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
          case (state[i])
            S_IDLE: begin
              if (req[i]) begin
                addr[i] <= '0;
                if (len[i] != '0) begin
                  state[i] <= S_PLAY;
                  busy[i]  <= 1'b1;
                end
              end
            end
            S_PLAY: begin
              if (req[i]) begin
                addr[i] <= '0;
              end else if (at_end[i]) begin
                addr[i] <= '0;
                if (!loop[i]) begin
                  state[i] <= S_IDLE;
                  busy[i]  <= 1'b0;
                end
              end else begin
                addr[i] <= addr[i] + 1'b1;
              end
            end
            default: begin
              state[i] <= S_IDLE;
              busy[i]  <= 1'b0;
              addr[i]  <= '0;
            end
          endcase
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
        pending <= pending | trig_edge;
      end
    end
  end

endmodule
